// File: rtl/fp_mac_acc_if.sv
// Operand-beat handshake (in_*) and normalized-result handshake (out_*) for fp_mac_acc.
// out_zcnt exists only when FP_MAC_ACC_ZSKIP_EN is defined.
interface fp_mac_acc_if #(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int NTAP_W = 6
);
    localparam int AW = 2 * MAN_W + 2;

    logic [NTAP_W-1:0] cfg_ntaps;
    logic              in_valid;
    logic              in_ready;
    logic              in_a_sgn;
    logic              in_b_sgn;
    logic [EXP_W-1:0]  in_a_exp;
    logic [EXP_W-1:0]  in_b_exp;
    logic [MAN_W-1:0]  in_a_man;
    logic [MAN_W-1:0]  in_b_man;
    logic              out_valid;
    logic              out_ready;
    logic              out_sgn;
    logic [EXP_W:0]    out_exp;
    logic [AW-1:0]     out_man;
    logic              out_ovf;
`ifdef FP_MAC_ACC_ZSKIP_EN
    logic [NTAP_W:0]   out_zcnt;
`endif

    modport master (
`ifdef FP_MAC_ACC_ZSKIP_EN
        input  out_zcnt,
`endif
        output cfg_ntaps, in_valid, in_a_sgn, in_b_sgn, in_a_exp, in_b_exp, in_a_man, in_b_man,
        input  in_ready,
        input  out_valid, out_sgn, out_exp, out_man, out_ovf,
        output out_ready
    );

    modport slave (
`ifdef FP_MAC_ACC_ZSKIP_EN
        output out_zcnt,
`endif
        input  cfg_ntaps, in_valid, in_a_sgn, in_b_sgn, in_a_exp, in_b_exp, in_a_man, in_b_man,
        output in_ready,
        output out_valid, out_sgn, out_exp, out_man, out_ovf,
        input  out_ready
    );
endinterface

// File: rtl/fp_mac_acc.sv
// Floating-point multiply-accumulate over a frame of cfg_ntaps+1 beats; FP_MAC_ACC_ZSKIP_EN gates zero products and adds out_zcnt.
// Latency: result valid 3 cycles after the last beat is accepted; one beat absorbed per cycle.
// Backpressure: in_ready low from last beat until the result handshake; result held while out_ready is low.
module fp_mac_acc #(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int NTAP_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_mac_acc_if.slave bus
);
    localparam int AW  = 2 * MAN_W + 2;
    localparam int AEW = EXP_W + 3;
    localparam int LZW = $clog2(AW);
    localparam logic [AEW:0] EMAX = (AEW+1)'((1 << (EXP_W + 1)) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t            state;
    logic              in_rdy_q;
    logic [NTAP_W-1:0] ntaps_q, tap_cnt;
    logic              accept, start, acc_en;

    assign accept       = bus.in_valid && in_rdy_q;
    assign start        = accept && (state == IDLE);
    assign bus.in_ready = in_rdy_q;

    logic             p0_vld, p0_zero, p0_sgn;
    logic [EXP_W-1:0] p0_ea, p0_eb;
    logic [MAN_W-1:0] p0_ma, p0_mb;
    logic             p1_vld, p1_sgn;
    logic [AEW-1:0]   p1_exp;
    logic [AW-1:0]    p1_man;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_vld <= 1'b0; p0_zero <= 1'b0; p0_sgn <= 1'b0;
            p0_ea  <= '0;   p0_eb   <= '0;   p0_ma  <= '0; p0_mb <= '0;
            p1_vld <= 1'b0; p1_sgn  <= 1'b0; p1_exp <= '0; p1_man <= '0;
        end else begin
            p0_vld <= accept;
            if (accept) begin
                p0_zero <= (bus.in_a_exp == '0) || (bus.in_b_exp == '0);
                p0_sgn  <= bus.in_a_sgn ^ bus.in_b_sgn;
                p0_ea   <= bus.in_a_exp;
                p0_eb   <= bus.in_b_exp;
                p0_ma   <= bus.in_a_man;
                p0_mb   <= bus.in_b_man;
            end
            p1_vld <= p0_vld;
            // Exponent rebased so the product reads as p1_man/2^(AW-1) * 2^(p1_exp-OB).
            if (p0_vld) begin
                p1_sgn <= p0_sgn && !p0_zero;
                p1_exp <= p0_zero ? '0 : AEW'(p0_ea) + AEW'(p0_eb) + AEW'(2);
                p1_man <= p0_zero ? '0 : AW'({1'b1, p0_ma}) * AW'({1'b1, p0_mb});
            end
        end
    end

    logic           acc_sgn, sum_sgn;
    logic [AEW-1:0] acc_exp, sum_exp, e_max, e_dif;
    logic [AW-1:0]  acc_man, sum_man, a_al, b_al;
    logic [AW:0]    raw;

    always_comb begin
        if (acc_exp >= p1_exp) begin
            e_max = acc_exp; e_dif = acc_exp - p1_exp; a_al = acc_man; b_al = p1_man >> e_dif;
        end else begin
            e_max = p1_exp; e_dif = p1_exp - acc_exp; a_al = acc_man >> e_dif; b_al = p1_man;
        end
        if (acc_sgn == p1_sgn) begin
            raw = {1'b0, a_al} + {1'b0, b_al}; sum_sgn = acc_sgn;
        end else if (a_al >= b_al) begin
            raw = {1'b0, a_al - b_al}; sum_sgn = acc_sgn;
        end else begin
            raw = {1'b0, b_al - a_al}; sum_sgn = p1_sgn;
        end
        if (raw[AW]) begin
            sum_man = raw[AW:1]; sum_exp = e_max + AEW'(1);
        end else begin
            sum_man = raw[AW-1:0]; sum_exp = e_max;
        end
        // An empty accumulator takes the product as-is so no precision is lost to a stale exponent.
        if (acc_man == '0) begin
            sum_sgn = p1_sgn; sum_exp = p1_exp; sum_man = p1_man;
        end
        if (sum_man == '0) sum_sgn = 1'b0;
    end

`ifdef FP_MAC_ACC_ZSKIP_EN
    logic            p1_zero;
    logic [NTAP_W:0] zcnt, zcnt_q;
    assign p1_zero = (p1_man == '0);
    assign acc_en  = p1_vld && !p1_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                zcnt <= '0;
        else if (start)            zcnt <= '0;
        else if (p1_vld && p1_zero) zcnt <= zcnt + (NTAP_W+1)'(1);
    end
    assign bus.out_zcnt = zcnt_q;
`else
    assign acc_en = p1_vld;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sgn <= 1'b0; acc_exp <= '0; acc_man <= '0;
        end else if (start) begin
            acc_sgn <= 1'b0; acc_exp <= '0; acc_man <= '0;
        end else if (acc_en) begin
            acc_sgn <= sum_sgn; acc_exp <= sum_exp; acc_man <= sum_man;
        end
    end

    logic [LZW-1:0] msb, lz;
    logic [AEW+1:0] ne;
    logic [AW-1:0]  norm_man;
    logic           res_zero, res_sat;

    always_comb begin
        msb = '0;
        for (int i = 0; i < AW; i++) if (acc_man[i]) msb = LZW'(i);
        lz       = LZW'(AW - 1) - msb;
        ne       = {2'b00, acc_exp} - (AEW+2)'(lz);
        norm_man = acc_man << lz;
    end
    assign res_zero = (acc_man == '0) || ne[AEW+1] || (ne == '0);
    assign res_sat  = !res_zero && (ne[AEW:0] > EMAX);

    logic              out_vld_q, out_sgn_q, out_ovf_q;
    logic [EXP_W:0]    out_exp_q;
    logic [AW-1:0]     out_man_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE; in_rdy_q <= 1'b0; ntaps_q <= '0; tap_cnt <= '0;
            out_vld_q <= 1'b0; out_sgn_q <= 1'b0; out_exp_q <= '0; out_man_q <= '0; out_ovf_q <= 1'b0;
`ifdef FP_MAC_ACC_ZSKIP_EN
            zcnt_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_rdy_q <= 1'b1;
                    if (accept) begin
                        ntaps_q <= bus.cfg_ntaps;
                        tap_cnt <= NTAP_W'(1);
                        if (bus.cfg_ntaps == '0) begin
                            state <= DRAIN; in_rdy_q <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: if (accept) begin
                    if (tap_cnt == ntaps_q) begin
                        state <= DRAIN; in_rdy_q <= 1'b0;
                    end else begin
                        tap_cnt <= tap_cnt + NTAP_W'(1);
                    end
                end
                DRAIN: if (!p0_vld && !p1_vld) begin
                    state     <= OUT;
                    out_vld_q <= 1'b1;
                    out_sgn_q <= res_zero ? 1'b0 : acc_sgn;
                    out_exp_q <= res_zero ? '0 : (res_sat ? '1 : ne[EXP_W:0]);
                    out_man_q <= res_zero ? '0 : (res_sat ? '1 : norm_man);
                    out_ovf_q <= res_sat;
`ifdef FP_MAC_ACC_ZSKIP_EN
                    zcnt_q    <= zcnt;
`endif
                end
                OUT: if (bus.out_ready) begin
                    state <= IDLE; out_vld_q <= 1'b0; in_rdy_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_sgn   = out_sgn_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_man   = out_man_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_fp_mac_acc.sv
// Self-checking bench for fp_mac_acc: table of frames plus hold, saturation and mid-frame reset sequences.
module tb_fp_mac_acc;
    localparam int EXP_W = 5, MAN_W = 10, NTAP_W = 6, AW = 22, NV = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fp_mac_acc_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .NTAP_W(NTAP_W)) bus ();
    fp_mac_acc #(.EXP_W(EXP_W), .MAN_W(MAN_W), .NTAP_W(NTAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic sgn; logic [EXP_W:0] ex; logic [AW-1:0] man; logic ovf; logic [NTAP_W:0] zc;
    } exp_t;
    typedef struct {
        logic [NTAP_W-1:0] nt;
        logic [3:0][15:0]  a;
        logic [3:0][15:0]  b;
        exp_t              e;
    } vec_t;

    vec_t vt[NV];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic setv(input int i, input logic [NTAP_W-1:0] nt, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic [EXP_W:0] ex, input logic [AW-1:0] m, input logic o,
                        input logic [NTAP_W:0] z);
        vt[i].nt = nt; vt[i].a = a; vt[i].b = b;
        vt[i].e  = '{sgn: s, ex: ex, man: m, ovf: o, zc: z};
    endtask

    task automatic drive_ops(input logic [15:0] a, input logic [15:0] b);
        bus.in_a_sgn = a[15]; bus.in_a_exp = a[14:10]; bus.in_a_man = a[9:0];
        bus.in_b_sgn = b[15]; bus.in_b_exp = b[14:10]; bus.in_b_man = b[9:0];
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic [NTAP_W-1:0] nt);
        int w;
        @(negedge clk);
        bus.cfg_ntaps = nt; drive_ops(a, b); bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
        chk("in_ready_for_beat", bus.in_ready, 1);
        @(posedge clk);
    endtask

    // Called right after the accept edge of the last beat; garbage beats offered meanwhile must be ignored.
    task automatic wait_out(input string nm);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1; drive_ops(16'($urandom), 16'($urandom)); bus.cfg_ntaps = 6'($urandom);
        n = 0;
        while (!bus.out_valid && n < 30) begin @(posedge clk); n++; @(negedge clk); end
        chk({nm, "_latency"}, n, 3);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        chk({nm, "_sgn"}, bus.out_sgn, e.sgn);
        chk({nm, "_exp"}, bus.out_exp, e.ex);
        chk({nm, "_man"}, bus.out_man, e.man);
        chk({nm, "_ovf"}, bus.out_ovf, e.ovf);
`ifdef FP_MAC_ACC_ZSKIP_EN
        chk({nm, "_zcnt"}, bus.out_zcnt, e.zc);
`endif
    endtask

    task automatic handshake(input string nm);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({nm, "_in_ready_after"}, bus.in_ready, 1);
        chk({nm, "_out_valid_after"}, bus.out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   seen;
        //   idx ntaps a{3,2,1,0}                 b{3,2,1,0}                 sgn exp man        ovf zcnt
        setv(0,  0, 64'h0000_0000_0000_3C00, 64'h0000_0000_0000_3C00, 0, 31, 22'h200000, 0, 0);
        setv(1,  2, 64'h0000_3800_BC00_3E00, 64'h0000_3C00_3C00_4000, 0, 32, 22'h280000, 0, 0);
        setv(2,  1, 64'h0000_0000_BC00_3C00, 64'h0000_0000_3C00_3C00, 0, 0,  22'h000000, 0, 0);
        setv(3,  1, 64'h0000_0000_3800_BC00, 64'h0000_0000_3C00_4000, 1, 31, 22'h300000, 0, 0);
        setv(4,  2, 64'h0000_83FF_3C00_0000, 64'h0000_3C00_3C00_4000, 0, 31, 22'h200000, 0, 2);
        setv(5,  1, 64'h0000_0000_8400_0401, 64'h0000_0000_0400_0400, 0, 0,  22'h000000, 0, 0);
        setv(6,  0, 64'h0000_0000_0000_7BFF, 64'h0000_0000_0000_7BFF, 0, 62, 22'h3FF001, 0, 0);
        setv(7,  1, 64'h0000_0000_7BFF_7BFF, 64'h0000_0000_7BFF_7BFF, 0, 63, 22'h3FF001, 0, 0);
        setv(8,  1, 64'h0000_0000_0400_3C00, 64'h0000_0000_0400_3C00, 0, 31, 22'h200000, 0, 0);
        setv(9,  1, 64'h0000_0000_4000_3800, 64'h0000_0000_4000_3C00, 0, 33, 22'h240000, 0, 0);
        setv(10, 3, 64'hBC00_BC00_BC00_BC00, 64'h3C00_4000_4000_4000, 1, 33, 22'h380000, 0, 0);

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.cfg_ntaps = '0; drive_ops(16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #10;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sgn",   bus.out_sgn, 0);
        chk("rst_out_exp",   bus.out_exp, 0);
        chk("rst_out_man",   bus.out_man, 0);
        chk("rst_out_ovf",   bus.out_ovf, 0);
        chk("rst_in_ready",  bus.in_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        chk("in_ready_before_edge", bus.in_ready, 0);
        @(posedge clk); @(negedge clk);
        chk("in_ready_first_edge", bus.in_ready, 1);

        for (int v = 0; v < NV; v++) begin
            sb_q.push_back(vt[v].e);
            for (int k = 0; k <= int'(vt[v].nt); k++)
                send_beat(vt[v].a[k], vt[v].b[k], (k == 0) ? vt[v].nt : ~vt[v].nt);
            wait_out($sformatf("vec%0d", v));
            handshake($sformatf("vec%0d", v));
        end

        // Result must hold while out_ready stays low, with beats offered and refused.
        e = '{sgn: 1, ex: 31, man: 22'h300000, ovf: 0, zc: 0};
        sb_q.push_back(e);
        send_beat(16'hBC00, 16'h3E00, 0);
        wait_out("hold");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; drive_ops(16'($urandom), 16'($urandom));
            chk($sformatf("hold%0d_out_valid", c), bus.out_valid, 1);
            chk($sformatf("hold%0d_sgn", c), bus.out_sgn, e.sgn);
            chk($sformatf("hold%0d_exp", c), bus.out_exp, e.ex);
            chk($sformatf("hold%0d_man", c), bus.out_man, e.man);
            chk($sformatf("hold%0d_in_ready", c), bus.in_ready, 0);
        end
        handshake("hold");

        // 64 taps of max-normal squared saturate.
        sb_q.push_back('{sgn: 0, ex: 63, man: 22'h3FFFFF, ovf: 1, zc: 0});
        for (int k = 0; k < 64; k++) send_beat(16'h7BFF, 16'h7BFF, (k == 0) ? 6'd63 : 6'd0);
        wait_out("sat");
        handshake("sat");

        // Reset after 2 of 4 beats discards the frame.
        send_beat(16'h3C00, 16'h3C00, 3);
        send_beat(16'h3C00, 16'h3C00, 0);
        @(negedge clk);
        rst_n = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("midrst_in_ready",  bus.in_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_man",   bus.out_man, 0);
        chk("midrst_out_ovf",   bus.out_ovf, 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_out_valid", seen, 0);
        sb_q.push_back(vt[0].e);
        send_beat(16'h3C00, 16'h3C00, 0);
        wait_out("post_rst");
        handshake("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
